// File: rtl/digit_serial_alu.sv
// rtl/digit_serial_alu.sv - digit-serial ALU: arith/logic one DIGIT per cycle, single-cycle shifts
//
// Optional feature macro: ALU_FLAGS_EN (builds the zero/ovf flag flops; otherwise both tie to 0)
//
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   start  - begin an operation (accepted only in IDLE)
//   select - [4] 0=arith/logic 1=shift, [3] 0=logic 1=arith, [2:0] opcode
//   a, b   - operands (WIDTH bits)
//   cin    - carry-in
//   busy   - high in RUN and DONE
//   done   - one-cycle completion pulse
//   y      - result, held until the next completion
//   cout   - carry-out or shifted-out bit
//   zero   - result-equals-zero flag
//   ovf    - signed overflow flag
module digit_serial_alu #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [4:0]       select,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] y,
   output logic             cout,
   output logic             zero,
   output logic             ovf
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

   if ((WIDTH % DIGIT) != 0 || WIDTH < 2 * DIGIT) begin : g_bad_params
      $error("digit_serial_alu: WIDTH must be a multiple of DIGIT and at least 2*DIGIT");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nxt;

   logic [WIDTH-1:0]       opa, opb;     // operands, shifted right one digit per RUN cycle
   logic [WIDTH-DIGIT-1:0] acc;          // result digits gathered so far, LSB digit lowest
   logic [3:0]             sel_q;
   logic                   carry;
   logic [CW-1:0]          cnt;

   logic                   accept, last_dig, ld;
   logic [DIGIT-1:0]       da, db, dx, dy, dlog, dres;
   logic [DIGIT:0]         dsum;
   logic                   c0, cnext;
   logic [WIDTH-1:0]       shy, y_new;
   logic                   shc, c_new;

   assign accept   = (state == IDLE) && start;
   assign last_dig = (cnt == LAST);

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = select[4] ? DONE : RUN;
         RUN:     if (last_dig) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // output logic
   always_comb begin
      busy = (state != IDLE);
      done = (state == DONE);
   end

   // Subtractions become additions of an inverted operand; the +1 rides in on the initial carry.
   always_comb begin
      case (select[2:0])
         3'b000, 3'b100:         c0 = cin;
         3'b001, 3'b010, 3'b101: c0 = 1'b1;
         default:                c0 = 1'b0;
      endcase
   end

   assign da = opa[DIGIT-1:0];
   assign db = opb[DIGIT-1:0];

   always_comb begin
      dx = da;
      dy = '0;
      case (sel_q[2:0])
         3'b000: dy = db;
         3'b001: dy = ~db;
         3'b011: dy = '1;            // A-1 as A + all-ones
         3'b101: begin dx = db; dy = ~da; end
         3'b111: dx = '0;
         default: dy = '0;
      endcase
   end

   assign dsum = {1'b0, dx} + {1'b0, dy} + {{DIGIT{1'b0}}, carry};

   always_comb begin
      case (sel_q[2:0])
         3'b000:  dlog = da & db;
         3'b001:  dlog = da | db;
         3'b010:  dlog = da ^ db;
         3'b011:  dlog = ~(da ^ db);
         3'b100:  dlog = ~da;
         3'b101:  dlog = ~(da & db);
         3'b110:  dlog = ~(da | db);
         default: dlog = db;
      endcase
   end

   assign dres  = sel_q[3] ? dsum[DIGIT-1:0] : dlog;
   assign cnext = sel_q[3] & dsum[DIGIT];

   always_comb begin
      case (select[1:0])
         2'b00:   begin shy = {a[WIDTH-2:0], 1'b0};       shc = a[WIDTH-1]; end
         2'b01:   begin shy = {1'b0, a[WIDTH-1:1]};       shc = a[0];       end
         2'b10:   begin shy = {a[WIDTH-2:0], a[WIDTH-1]}; shc = a[WIDTH-1]; end
         default: begin shy = {a[0], a[WIDTH-1:1]};       shc = a[0];       end
      endcase
   end

   // Result registers load only on entry to DONE: shift from IDLE, or the last RUN digit.
   assign ld    = (accept && select[4]) || (state == RUN && last_dig);
   assign y_new = (state == IDLE) ? shy : {dres, acc};
   assign c_new = (state == IDLE) ? shc : cnext;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opa   <= '0;
         opb   <= '0;
         acc   <= '0;
         sel_q <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         y     <= '0;
         cout  <= 1'b0;
      end else begin
         if (accept) begin
            opa   <= a;
            opb   <= b;
            sel_q <= select[3:0];
            carry <= select[3] & c0;
            cnt   <= '0;
         end else if (state == RUN) begin
            opa   <= opa >> DIGIT;
            opb   <= opb >> DIGIT;
            acc   <= y_new[WIDTH-1:DIGIT];
            carry <= cnext;
            cnt   <= last_dig ? '0 : cnt + 1'b1;
         end
         if (ld) begin
            y    <= y_new;
            cout <= c_new;
         end
      end
   end

`ifdef ALU_FLAGS_EN
   logic v_new;

   // Signed overflow: both addends share a sign that the sum does not (top digit only).
   always_comb begin
      v_new = 1'b0;
      if (state == RUN && sel_q[3]) begin
         case (sel_q[2:0])
            3'b000, 3'b001, 3'b010, 3'b011, 3'b101:
               v_new = (dx[DIGIT-1] == dy[DIGIT-1]) && (dsum[DIGIT-1] != dx[DIGIT-1]);
            default: v_new = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero <= 1'b0;
         ovf  <= 1'b0;
      end else if (ld) begin
         zero <= (y_new == '0);
         ovf  <= v_new;
      end
   end
`else
   assign zero = 1'b0;
   assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_digit_serial_alu.sv
// tb/tb_digit_serial_alu.sv - randomized self-checking bench for digit_serial_alu (16/4 and 32/8)
module tb_digit_serial_alu;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        st16, cin16, busy16, done16, cout16, zero16, ovf16;
   logic [4:0]  sel16;
   logic [15:0] a16, b16, y16;
   logic        st32, cin32, busy32, done32, cout32, zero32, ovf32;
   logic [4:0]  sel32;
   logic [31:0] a32, b32, y32;

   digit_serial_alu #(.WIDTH(16), .DIGIT(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(st16), .select(sel16), .a(a16), .b(b16), .cin(cin16),
      .busy(busy16), .done(done16), .y(y16), .cout(cout16), .zero(zero16), .ovf(ovf16));

   digit_serial_alu #(.WIDTH(32), .DIGIT(8)) dut32 (
      .clk(clk), .rst_n(rst_n), .start(st32), .select(sel32), .a(a32), .b(b32), .cin(cin32),
      .busy(busy32), .done(done32), .y(y32), .cout(cout32), .zero(zero32), .ovf(ovf32));

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ry(input int w);
      return (w == 16) ? 64'(y16) : 64'(y32);
   endfunction
   function automatic logic rbusy(input int w);  return (w == 16) ? busy16 : busy32; endfunction
   function automatic logic rdone(input int w);  return (w == 16) ? done16 : done32; endfunction
   function automatic logic rcout(input int w);  return (w == 16) ? cout16 : cout32; endfunction
   function automatic logic rzero(input int w);  return (w == 16) ? zero16 : zero32; endfunction
   function automatic logic rovf(input int w);   return (w == 16) ? ovf16  : ovf32;  endfunction

   task automatic drive(input int w, input logic s, input logic [4:0] sel,
                        input logic [63:0] a, input logic [63:0] b, input logic c);
      if (w == 16) begin
         st16 = s; sel16 = sel; a16 = a[15:0]; b16 = b[15:0]; cin16 = c;
      end else begin
         st32 = s; sel32 = sel; a32 = a[31:0]; b32 = b[31:0]; cin32 = c;
      end
   endtask

   task automatic drive_junk(input int w, input logic s);
      drive(w, s, 5'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
   endtask

   // Reference: plain integer arithmetic on the operand values.
   function automatic void model(input int w, input logic [4:0] s, input logic [63:0] ai,
                                 input logic [63:0] bi, input logic c,
                                 output logic [63:0] y, output logic co, output logic v);
      logic [63:0] m, a, b, r;
      longint sa, sb, t, lo, hi;
      logic chk_v;
      m  = (64'd1 << w) - 1;
      a  = ai & m;
      b  = bi & m;
      sa = a[w-1] ? longint'(a) - longint'(64'd1 << w) : longint'(a);
      sb = b[w-1] ? longint'(b) - longint'(64'd1 << w) : longint'(b);
      lo = -(longint'(1) << (w - 1));
      hi = (longint'(1) << (w - 1)) - 1;
      r = 0; t = 0; co = 0; v = 0; chk_v = 0;
      if (s[4]) begin
         case (s[1:0])
            2'b00: begin y = (a << 1) & m;                  co = a[w-1]; end
            2'b01: begin y = a >> 1;                        co = a[0];   end
            2'b10: begin y = ((a << 1) | (a >> (w-1))) & m; co = a[w-1]; end
            default: begin y = (a >> 1) | ({63'd0, a[0]} << (w-1)); co = a[0]; end
         endcase
      end else if (s[3]) begin
         case (s[2:0])
            3'd0: begin r = a + b + 64'(c);       t = sa + sb + longint'(c); chk_v = 1; end
            3'd1: begin r = a + (~b & m) + 1;     t = sa - sb;               chk_v = 1; end
            3'd2: begin r = a + 1;                t = sa + 1;                chk_v = 1; end
            3'd3: begin r = a + m;                t = sa - 1;                chk_v = 1; end
            3'd4: r = a + 64'(c);
            3'd5: begin r = b + (~a & m) + 1;     t = sb - sa;               chk_v = 1; end
            3'd6: r = a;
            default: r = 0;
         endcase
         y  = r & m;
         co = r[w];
         v  = chk_v && (t < lo || t > hi);
      end else begin
         case (s[2:0])
            3'd0: y = a & b;
            3'd1: y = a | b;
            3'd2: y = a ^ b;
            3'd3: y = ~(a ^ b) & m;
            3'd4: y = ~a & m;
            3'd5: y = ~(a & b) & m;
            3'd6: y = ~(a | b) & m;
            default: y = b;
         endcase
      end
   endfunction

   task automatic run_op(input int w, input logic [4:0] sel, input logic [63:0] a,
                         input logic [63:0] b, input logic c, input bit repulse);
      logic [63:0] ey, yprev;
      logic ec, ev, ez;
      int cyc, lat;
      bit got;
      model(w, sel, a, b, c, ey, ec, ev);
`ifdef ALU_FLAGS_EN
      ez = (ey == 0);
`else
      ez = 1'b0;
      ev = 1'b0;
`endif
      lat   = sel[4] ? 1 : 5;
      yprev = ry(w);
      @(negedge clk);
      drive(w, 1'b1, sel, a, b, c);
      @(posedge clk);
      #1 drive_junk(w, 1'b0);
      cyc = 0;
      got = 0;
      while (cyc < 20 && !got) begin
         @(negedge clk);
         cyc++;
         if (rdone(w)) got = 1;
         else begin
            check("busy_run", 64'(rbusy(w)), 64'd1);
            check("y_hold", ry(w), yprev);
            drive_junk(w, repulse && cyc >= 2 && cyc <= 4);
         end
      end
      drive_junk(w, 1'b0);
      check("latency", 64'(cyc), 64'(lat));
      check("y", ry(w), ey);
      check("cout", 64'(rcout(w)), 64'(ec));
      check("zero", 64'(rzero(w)), 64'(ez));
      check("ovf", 64'(rovf(w)), 64'(ev));
      check("busy_done", 64'(rbusy(w)), 64'd1);
      @(negedge clk);
      check("done_single", 64'(rdone(w)), 64'd0);
      check("busy_idle", 64'(rbusy(w)), 64'd0);
      check("y_after", ry(w), ey);
   endtask

   initial begin
      rst_n = 1'b0;
      drive(16, 1'b0, 5'd0, 0, 0, 1'b0);
      drive(32, 1'b0, 5'd0, 0, 0, 1'b0);
      repeat (3) @(negedge clk);
      check("rst_busy", 64'(busy16), 64'd0);
      check("rst_done", 64'(done16), 64'd0);
      check("rst_y", 64'(y16), 64'd0);
      check("rst_cout", 64'(cout16), 64'd0);
      check("rst_zero", 64'(zero16), 64'd0);
      check("rst_ovf", 64'(ovf16), 64'd0);
      check("rst_y32", 64'(y32), 64'd0);
      rst_n = 1'b1;

      run_op(16, 5'b01000, 64'hFFFF, 64'h0001, 1'b0, 0);
      run_op(16, 5'b01001, 64'h8000, 64'h0001, 1'b0, 0);
      run_op(16, 5'b10010, 64'h8001, 64'h0000, 1'b0, 0);
      run_op(16, 5'b10001, 64'h8001, 64'h0000, 1'b0, 0);
      run_op(16, 5'b00010, 64'hF0F0, 64'hFF00, 1'b0, 0);
      run_op(32, 5'b00010, 64'hF0F0F0F0, 64'hFF00FF00, 1'b0, 0);
      run_op(16, 5'b01000, 64'h1234, 64'h4321, 1'b1, 1);
      run_op(16, 5'b01011, 64'h0000, 64'h0000, 1'b0, 0);
      run_op(16, 5'b01101, 64'h7FFF, 64'h8000, 1'b0, 0);

      // reset in the third RUN cycle
      @(negedge clk);
      drive(16, 1'b1, 5'b01000, 64'h1111, 64'h2222, 1'b0);
      @(posedge clk);
      #1 drive_junk(16, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", 64'(busy16), 64'd0);
      check("midrst_y", 64'(y16), 64'd0);
      check("midrst_done", 64'(done16), 64'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("midrst_nodone", 64'(done16), 64'd0);
         if (i == 1) rst_n = 1'b1;
      end
      run_op(16, 5'b01000, 64'h1111, 64'h2222, 1'b0, 0);

      for (int i = 0; i < 60; i++)
         run_op(16, 5'($urandom), 64'($urandom), 64'($urandom), 1'($urandom), bit'($urandom));
      for (int i = 0; i < 20; i++)
         run_op(32, 5'($urandom), 64'($urandom), 64'($urandom), 1'($urandom), bit'($urandom));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/digit_serial_alu.md
DIGIT_SERIAL_ALU -- requirements
Module: digit_serial_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL have parameter DIGIT, default 4, bits processed per cycle. WIDTH % DIGIT == 0 and WIDTH >= 2*DIGIT are required; elaboration SHALL fail otherwise.
REQ-003 SHALL have port clk, input, 1, single clock; all flops rising-edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, request to begin an operation.
REQ-006 SHALL have port select, input, 5.
  - [4]: 0 = arith/logic, 1 = shift.
  - [3]: 0 = logic, 1 = arith.
  - [2:0]: opcode.
REQ-007 SHALL have port a, input, WIDTH, operand A.
REQ-008 SHALL have port b, input, WIDTH, operand B.
REQ-009 SHALL have port cin, input, 1, carry-in.
REQ-010 SHALL have port busy, output, 1, operation in progress.
REQ-011 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port y, output, WIDTH, result.
REQ-013 SHALL have port cout, output, 1, carry/borrow-out or shifted-out bit.
REQ-014 SHALL have port zero, output, 1, result-equals-zero flag.
REQ-015 SHALL have port ovf, output, 1, signed overflow flag.

Function
REQ-016 SHALL implement states IDLE, RUN, DONE: IDLE->RUN on start for arith/logic; IDLE->DONE on start for shift; RUN->DONE after the last digit; DONE->IDLE unconditionally.
REQ-017 SHALL capture a, b, select and cin only on the cycle start is accepted in IDLE; start in RUN or DONE SHALL be ignored with no side effect.
REQ-018 SHALL process arith/logic ops LSB digit first, one DIGIT per RUN cycle; done SHALL assert exactly WIDTH/DIGIT+1 cycles after the accepted start (5 cycles at defaults).
REQ-019 SHALL complete shift ops with done asserted exactly 1 cycle after the accepted start.
REQ-020 SHALL assert busy in RUN and DONE, and deassert it in IDLE.
REQ-021 SHALL implement logic ops (select[4:3]=00):
  - [2:0] 000: AND. 001: OR. 010: XOR. 011: XNOR. 100: NOT A. 101: NAND. 110: NOR. 111: pass B.
  - cout=0.
REQ-022 SHALL implement arith ops (select[4:3]=01):
  - [2:0] 000: A+B+cin. 001: A-B as A+~B+1. 010: A+1. 011: A-1. 100: A+cin. 101: B-A. 110: pass A. 111: 0.
  - Digit-to-digit carry SHALL be held in a 1-bit register; cout = final carry (carry-out, not borrow-inverted).
REQ-023 SHALL implement shift ops (select[4]=1) on select[1:0]:
  - 00: logical shift left by 1, cout=a[WIDTH-1].
  - 01: logical shift right by 1, cout=a[0].
  - 10: rotate left, cout=a[WIDTH-1].
  - 11: rotate right, cout=a[0].
  - select[3:2] ignored.
REQ-024 SHALL update y, cout, zero and ovf only in the DONE-entry cycle, and hold them until the next completion.
REQ-025 SHALL leave all outputs unchanged when start is asserted while busy.

Reset
REQ-026 SHALL, while rst_n=0, force state=IDLE and y=0, cout=0, zero=0, ovf=0, busy=0, done=0, carry register=0, digit counter=0, regardless of the clock.
REQ-027 SHALL, on reset asserted mid-RUN, discard the partial result with no done pulse; the first start after release SHALL behave as from cold reset.

Configuration
REQ-028 SHALL compile the zero/ovf flag logic only when ALU_FLAGS_EN is defined.
  - With ALU_FLAGS_EN: zero = (y==0); ovf = signed overflow for arith ops 000/001/010/011/101, else 0.
  - Without ALU_FLAGS_EN: zero and ovf SHALL be tied to 0 and no flag flops inferred; ports remain present.

Verification
REQ-029 SHALL cover WIDTH=16, DIGIT=4: start with select=01000, a=16'hFFFF, b=16'h0001, cin=0 -> done on cycle 5, y=16'h0000, cout=1, zero=1 (with ALU_FLAGS_EN).
REQ-030 SHALL cover select=01001, a=16'h8000, b=16'h0001 -> y=16'h7FFF, cout=1, ovf=1 (with ALU_FLAGS_EN).
REQ-031 SHALL cover select=10010, a=16'h8001 -> done on cycle 1, y=16'h0003, cout=1; then select=10001 with the same a -> y=16'h4000, cout=1.
REQ-032 SHALL cover start re-pulsed in cycles 2-4 of an add -> ignored; y equals the first operation's result; single done pulse.
REQ-033 SHALL cover rst_n pulled low in cycle 3 of RUN -> busy=0, y=0 immediately; no done; the next op after release is correct.
REQ-034 SHALL cover select=00010, a=16'hF0F0, b=16'hFF00 -> y=16'h0FF0, cout=0, done on cycle 5; rerun with WIDTH=32, DIGIT=8 -> done on cycle 5.
